// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU.
//
// Accepts one operation at a time over a valid/ready input channel. Most
// opcodes finish in the cycle after they are accepted. SHLN/SHRN shift one
// bit per cycle, and MUL runs a W-cycle shift-add. The result and its status
// flags are held in registers. They stay stable on the output channel until
// the consumer takes them.
//
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous, active-low reset
//   In_valid   request present           In_ready   request accepted this cycle
//   OP         opcode                    InputA/B   operands
//   Out_valid  result present            Out_ready  consumer takes result
//   Out        result                    Zero/Parity/Odd/Carry  status flags
//   Busy       multi-cycle operation in progress
module seq_alu #(
    parameter int W   = 8,
    parameter int OPW = 4,
    parameter int SW  = $clog2(W)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           In_valid,
    output logic           In_ready,
    input  logic [OPW-1:0] OP,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    output logic           Out_valid,
    input  logic           Out_ready,
    output logic [W-1:0]   Out,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd,
    output logic           Carry,
    output logic           Busy
);

    // Counter must be able to hold W for the multiply.
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_LSH  = OPW'(1);
    localparam logic [OPW-1:0] OP_RSH  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5);
    localparam logic [OPW-1:0] OP_GEQ  = OPW'(6);
    localparam logic [OPW-1:0] OP_EQ   = OPW'(7);
    localparam logic [OPW-1:0] OP_NEQ  = OPW'(8);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(9);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(10);
    localparam logic [OPW-1:0] OP_SHLN = OPW'(11);
    localparam logic [OPW-1:0] OP_SHRN = OPW'(12);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(13);

    logic [1:0]     state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   work_q, work_d;      // shift value, or multiplier for MUL
    logic [2*W-1:0] mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [2*W-1:0] prod_q, prod_d;      // partial product
    logic           cbit_q, cbit_d;      // last bit shifted out
    logic [W-1:0]   out_q, out_d;
    logic           zero_q, zero_d;
    logic           par_q, par_d;
    logic           odd_q, odd_d;
    logic           carry_q, carry_d;

    logic           accept;
    logic           load;
    logic [W-1:0]   res;
    logic           res_c;
    logic [SW-1:0]  shamt;

    // Returns {carry, result} for every opcode that completes in one cycle.
    // SHLN/SHRN only reach this path with a zero shift amount.
    function automatic logic [W:0] alu_single(input logic [OPW-1:0] op,
                                              input logic [W-1:0]   a,
                                              input logic [W-1:0]   b);
        logic [W:0] r;
        logic [W:0] diff;
        r    = '0;
        diff = {1'b0, a} - {1'b0, b};
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_LSH:  r = {a[W-1], a << 1};
            OP_RSH:  r = {a[0], a >> 1};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_NEG:  r = {1'b0, ~a + W'(1)};
            OP_GEQ:  r = {1'b0, W'(a >= b)};
            OP_EQ:   r = {1'b0, W'(a == b)};
            OP_NEQ:  r = {1'b0, W'(a != b)};
            OP_SUB:  r = {~diff[W], diff[W-1:0]};   // carry = no borrow
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHLN: r = {1'b0, a};
            OP_SHRN: r = {1'b0, a};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign In_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & Out_ready);
    assign accept    = In_valid & In_ready;
    assign shamt     = InputB[SW-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cbit_d  = cbit_q;
        load    = 1'b0;
        res     = '0;
        res_c   = 1'b0;

        case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    prod_d  = prod_q + (work_q[0] ? mcand_q : '0);
                    mcand_d = mcand_q << 1;
                    work_d  = work_q >> 1;
                end else if (op_q == OP_SHLN) begin
                    work_d = work_q << 1;
                    cbit_d = work_q[W-1];
                end else begin
                    work_d = work_q >> 1;
                    cbit_d = work_q[0];
                end
                // The last step's outcome goes straight into the result registers.
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                    if (op_q == OP_MUL) begin
                        res   = prod_d[W-1:0];
                        res_c = |prod_d[2*W-1:W];
                    end else begin
                        res   = work_d;
                        res_c = cbit_d;
                    end
                end
            end
            S_DONE: begin
                if (Out_ready && !In_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Launch a new op from IDLE, or back-to-back from DONE.
        if (accept) begin
            op_d = OP;
            if (((OP == OP_SHLN) || (OP == OP_SHRN)) && (shamt != '0)) begin
                state_d = S_BUSY;
                cnt_d   = CW'(shamt);
                work_d  = InputA;
                cbit_d  = 1'b0;
            end else if (OP == OP_MUL) begin
                state_d = S_BUSY;
                cnt_d   = CW'(W);
                work_d  = InputB;
                mcand_d = {{W{1'b0}}, InputA};
                prod_d  = '0;
            end else begin
                state_d        = S_DONE;
                load           = 1'b1;
                {res_c, res}   = alu_single(OP, InputA, InputB);
            end
        end

        out_d   = load ? res    : out_q;
        zero_d  = load ? ~|res  : zero_q;
        par_d   = load ? ^res   : par_q;
        odd_d   = load ? res[0] : odd_q;
        carry_d = load ? res_c  : carry_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cbit_q  <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            par_q   <= 1'b0;
            odd_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cbit_q  <= cbit_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            par_q   <= par_d;
            odd_q   <= odd_d;
            carry_q <= carry_d;
        end
    end

    assign Out       = out_q;
    assign Zero      = zero_q;
    assign Parity    = par_q;
    assign Odd       = odd_q;
    assign Carry     = carry_q;
    assign Out_valid = (state_q == S_DONE);
    assign Busy      = (state_q == S_BUSY);

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: table of vectors plus hand-written corner sequences,
// with an in-order scoreboard checked by a monitor on the falling edge.
module tb_seq_alu;

    localparam int W   = 8;
    localparam int OPW = 4;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           In_valid;
    logic           In_ready;
    logic [OPW-1:0] OP;
    logic [W-1:0]   InputA;
    logic [W-1:0]   InputB;
    logic           Out_valid;
    logic           Out_ready;
    logic [W-1:0]   Out;
    logic           Zero;
    logic           Parity;
    logic           Odd;
    logic           Carry;
    logic           Busy;

    always #5 Clk = ~Clk;

    seq_alu #(.W(W), .OPW(OPW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .OP        (OP),
        .InputA    (InputA),
        .InputB    (InputB),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out       (Out),
        .Zero      (Zero),
        .Parity    (Parity),
        .Odd       (Odd),
        .Carry     (Carry),
        .Busy      (Busy)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       c;
        int         lat;
        int         busy;
    } vec_t;

    typedef struct {
        logic [7:0] out;
        logic       c;
        int         lat;
        int         busy;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    int   ncmp     = 0;
    int   nerr     = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    bit   seen_valid = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_result(input exp_t e);
        check("out",    32'(Out),    32'(e.out));
        check("zero",   32'(Zero),   32'(e.out == 8'h00));
        check("parity", 32'(Parity), 32'(^e.out));
        check("odd",    32'(Odd),    32'(e.out[0]));
        check("carry",  32'(Carry),  32'(e.c));
    endtask

    // Falling-edge monitor: latency and Busy-cycle count at first Out_valid,
    // result values at the handshake.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                busy_cnt   = 0;
                seen_valid = 1'b0;
            end else begin
                if (Busy) busy_cnt++;
                if (Out_valid && !seen_valid) begin
                    seen_valid = 1'b1;
                    if (sbq.size() == 0) begin
                        ncmp++;
                        nerr++;
                        $display("FAIL unexpected_valid: Out_valid=1 with no pending op, Out=%0h", Out);
                    end else begin
                        check("latency",     32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
                        check("busy_cycles", 32'(busy_cnt),             32'(sbq[0].busy));
                    end
                    busy_cnt = 0;
                end
                if (Out_valid && Out_ready && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk_result(e);
                    seen_valid = 1'b0;
                end
            end
        end
    endtask

    // Drive one request; call at posedge+1, returns at posedge+1 after accept.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eo, input logic ec, input int lat, input int busy,
                         input bit push);
        int   n;
        exp_t e;
        n        = 0;
        OP       = op;
        InputA   = a;
        InputB   = b;
        In_valid = 1'b1;
        @(negedge Clk);
        while (!In_ready && n < 100) begin
            n++;
            @(negedge Clk);
        end
        if (!In_ready) begin
            ncmp++;
            nerr++;
            $display("FAIL accept_timeout: In_ready=%0b, expected 1 within 100 cycles", In_ready);
        end else if (push) begin
            e.out  = eo;
            e.c    = ec;
            e.lat  = lat;
            e.busy = busy;
            e.acc  = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
        OP       = 4'($urandom);
        InputA   = 8'($urandom);
        InputB   = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            n++;
            @(negedge Clk);
        end
        if (sbq.size() != 0) begin
            ncmp++;
            nerr++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sbq.size());
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_cleared();
        check("rst_out",       32'(Out),       32'h0);
        check("rst_zero",      32'(Zero),      32'h0);
        check("rst_parity",    32'(Parity),    32'h0);
        check("rst_odd",       32'(Odd),       32'h0);
        check("rst_carry",     32'(Carry),     32'h0);
        check("rst_out_valid", 32'(Out_valid), 32'h0);
        check("rst_busy",      32'(Busy),      32'h0);
        check("rst_in_ready",  32'(In_ready),  32'h1);
    endtask

    vec_t vt[26];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op     a      b      out    c     lat busy
        vt[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1, 0};
        vt[1]  = '{4'd9,  8'h05, 8'h07, 8'hFE, 1'b0, 1, 0};
        vt[2]  = '{4'd11, 8'h83, 8'hF2, 8'h0C, 1'b0, 3, 2};
        vt[3]  = '{4'd12, 8'hB5, 8'h08, 8'hB5, 1'b0, 1, 0};
        vt[4]  = '{4'd13, 8'd20, 8'd13, 8'h04, 1'b1, 9, 8};
        vt[5]  = '{4'd13, 8'd15, 8'd17, 8'hFF, 1'b0, 9, 8};
        vt[6]  = '{4'd14, 8'h12, 8'h34, 8'h00, 1'b0, 1, 0};
        vt[7]  = '{4'd15, 8'hAB, 8'hCD, 8'h00, 1'b0, 1, 0};
        vt[8]  = '{4'd6,  8'd3,  8'd200, 8'h00, 1'b0, 1, 0};
        vt[9]  = '{4'd6,  8'd200, 8'd3, 8'h01, 1'b0, 1, 0};
        vt[10] = '{4'd1,  8'h81, 8'h00, 8'h02, 1'b1, 1, 0};
        vt[11] = '{4'd2,  8'h81, 8'h00, 8'h40, 1'b1, 1, 0};
        vt[12] = '{4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1, 0};
        vt[13] = '{4'd5,  8'h01, 8'h00, 8'hFF, 1'b0, 1, 0};
        vt[14] = '{4'd8,  8'h05, 8'h06, 8'h01, 1'b0, 1, 0};
        vt[15] = '{4'd10, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1, 0};
        vt[16] = '{4'd12, 8'h85, 8'h03, 8'h10, 1'b1, 4, 3};
        vt[17] = '{4'd11, 8'h42, 8'h07, 8'h00, 1'b1, 8, 7};
        vt[18] = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1, 0};
        vt[19] = '{4'd9,  8'h07, 8'h05, 8'h02, 1'b1, 1, 0};
        vt[20] = '{4'd7,  8'h03, 8'h04, 8'h00, 1'b0, 1, 0};
        vt[21] = '{4'd4,  8'hA0, 8'h05, 8'hA5, 1'b0, 1, 0};
        vt[22] = '{4'd12, 8'h80, 8'h0F, 8'h01, 1'b0, 8, 7};
        vt[23] = '{4'd11, 8'h01, 8'hFF, 8'h80, 1'b0, 8, 7};
        vt[24] = '{4'd5,  8'h00, 8'h00, 8'h00, 1'b0, 1, 0};
        vt[25] = '{4'd13, 8'hFF, 8'hFF, 8'h01, 1'b1, 9, 8};

        Reset     = 1'b0;
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        OP        = '0;
        InputA    = '0;
        InputB    = '0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge Clk);
        #1;
        chk_cleared();
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].out, vt[i].c, vt[i].lat, vt[i].busy, 1'b1);
        end
        drain();

        // Backpressure: EQ result held for 5 cycles, stray request ignored.
        Out_ready = 1'b0;
        issue(4'd7, 8'd9, 8'd9, 8'h01, 1'b0, 1, 0, 1'b1);
        OP       = 4'd0;
        InputA   = 8'h11;
        InputB   = 8'h22;
        In_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check("bp_out_valid", 32'(Out_valid), 32'h1);
            check("bp_out",       32'(Out),       32'h01);
            check("bp_zero",      32'(Zero),      32'h0);
            check("bp_parity",    32'(Parity),    32'h1);
            check("bp_odd",       32'(Odd),       32'h1);
            check("bp_carry",     32'(Carry),     32'h0);
            check("bp_in_ready",  32'(In_ready),  32'h0);
        end
        @(posedge Clk);
        #1;
        Out_ready = 1'b1;
        issue(4'd4, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1, 0, 1'b1);
        drain();

        // Reset during the third BUSY cycle of a multiply.
        issue(4'd13, 8'd20, 8'd13, 8'h00, 1'b0, 0, 0, 1'b0);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        check("mul_busy_before_reset", 32'(Busy), 32'h1);
        Reset = 1'b0;
        #1;
        chk_cleared();
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("idle_after_reset", 32'(Out_valid | Busy), 32'h0);
        issue(4'd0, 8'd3, 8'd4, 8'h07, 1'b0, 1, 0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Adds multi-cycle operations (variable shifts, iterative multiply), registered status flags and valid/ready flow control on both sides.
- Sits between the decode/register-file stage and writeback. The control FSM stalls issue while In_ready is low.

Parameters:
- W, 8, datapath width in bits (W >= 4, power of two).
- OPW, 4, opcode width.
- SW, $clog2(W), width of the shift-amount field taken from InputB.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- In_valid  input  1  operation request.
- In_ready  output  1  block can accept a request this cycle.
- OP  input  OPW  opcode, sampled on accept.
- InputA  input  W  operand A, sampled on accept.
- InputB  input  W  operand B, sampled on accept.
- Out_valid  output  1  result and flags valid.
- Out_ready  input  1  consumer accepts the result.
- Out  output  W  result.
- Zero  output  1  Out == 0.
- Parity  output  1  ^Out.
- Odd  output  1  Out[0].
- Carry  output  1  op-specific carry/overflow (see Behaviour).
- Busy  output  1  FSM in BUSY.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; Out, all flags, Out_valid and Busy = 0.
  - Any in-flight op is discarded, including mid-BUSY.
- Opcodes:
  - 0 ADD: A+B, Carry = carry-out.
  - 1 LSH: A<<1, Carry = A[W-1].
  - 2 RSH: A>>1 logical, Carry = A[0].
  - 3 AND: bitwise.
  - 4 OR: bitwise.
  - 5 NEG: ~A+1.
  - 6 GEQ: unsigned A>=B, zero-extended 0/1.
  - 7 EQ: A==B, zero-extended 0/1.
  - 8 NEQ: A!=B, zero-extended 0/1.
  - 9 SUB: A-B, Carry = 1 when no borrow (A>=B).
  - 10 XOR: bitwise.
  - 11 SHLN: A << B[SW-1:0], iterative, one bit per cycle, Carry = last bit shifted out.
  - 12 SHRN: logical A >> B[SW-1:0], iterative, Carry = last bit shifted out.
  - 13 MUL: unsigned shift-add over W cycles; Out = low W bits of product, Carry = 1 if high W bits are nonzero.
  - 14, 15: no-op, Out = 0.
  - Carry = 0 for every op not listed with a Carry rule.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - In_ready=1.
  - On In_valid, latch OP/A/B.
  - Single-cycle ops, and SHLN/SHRN with amount 0: go to DONE next edge.
  - SHLN/SHRN with amount k>0: go to BUSY with counter=k.
  - MUL: go to BUSY with counter=W.
- BUSY:
  - In_ready=0, Busy=1; one step per cycle, counter decrements.
  - When the counter reaches 0, the result is registered and the FSM goes to DONE.
- DONE:
  - Out_valid=1.
  - Out and all flags are held stable while Out_ready=0.
  - Out_ready=1 with In_valid=0: go to IDLE, Out_valid drops.
  - Out_ready=1 with In_valid=1: back-to-back accept. The new op is latched in the same cycle (In_ready = DONE & Out_ready) and the next state follows the IDLE rules.
  - In_ready=0 in DONE when Out_ready=0.
- Latency (accept edge to Out_valid): single-cycle ops 1; shifts k+1 (k=0 gives 1); MUL W+1.
- Flags:
  - Zero, Parity and Odd are computed from the final result and registered together with Out.
  - Out and flags never change while Out_valid=1 and Out_ready=0.
- Width rules: all arithmetic is modulo 2^W; shift amounts use only B[SW-1:0] and ignore the upper bits of B.
- Inputs are ignored while In_ready=0; changing OP/A/B mid-BUSY has no effect.

Test Plan:
- Reset mid-MUL: assert Reset low during cycle 3 of BUSY -> all outputs 0 immediately; IDLE on release; next ADD 3+4 -> Out=7 after 1 cycle.
- ADD 8'hFF+8'h01 -> Out=0, Zero=1, Carry=1, Parity=0, latency 1. SUB 5-7 -> Out=8'hFE, Carry=0.
- SHLN A=8'b1000_0011, B=8'hF2 (amount 2) -> Busy for 2 cycles, Out=8'h0C, Carry=0, Out_valid on cycle 3. SHRN amount 0 -> Out=A, latency 1.
- MUL 8'd20*8'd13 -> Busy 8 cycles, Out=8'h04 (260 mod 256), Carry=1. MUL 15*17 -> Out=8'hFF, Carry=0, Parity=0, Odd=1.
- Backpressure: hold Out_ready=0 for 5 cycles after an EQ result (A=B=9 -> Out=1) -> Out, flags and Out_valid stable, In_ready=0. Then Out_ready=1 with In_valid=1 (OR 8'hF0|8'h0F) -> new op accepted that cycle, Out=8'hFF one cycle later.
- Opcodes 14/15 and GEQ 3>=200 -> Out=0, Zero=1, Carry=0.
